// File: rtl/change_dispenser_pkg.sv
// change_pkg: shared types and constants for the change dispenser.
//   coin_idx_t - 2-bit coin index (0 = 100c, 1 = 25c, 2 = 10c, 3 = 5c)
//   COIN_VAL   - cent value of each coin index, largest first
//   err_t      - completion status reported with done
//   state_t    - dispenser FSM states
package change_pkg;

    typedef logic [1:0] coin_idx_t;

    localparam int NUM_COINS = 4;
    localparam int unsigned COIN_VAL [NUM_COINS] = '{100, 25, 10, 5};

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_UNPAYABLE = 2'd1,
        ERR_TIMEOUT   = 2'd2
    } err_t;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ,
        DONE
    } state_t;

    function automatic int unsigned coin_value(input coin_idx_t idx);
        return COIN_VAL[idx];
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: coin hopper handshake bundle.
//   coin_req     - dispenser -> hopper, request one coin (held until ack/timeout)
//   coin_sel     - dispenser -> hopper, index of the requested coin
//   coin_ack     - hopper -> dispenser, requested coin was ejected
//   hopper_empty - hopper -> dispenser, per-coin empty flags (bit i = coin index i)
// Modports: master = dispenser side, slave = hopper side.
interface change_dispenser_if;
    import change_pkg::*;

    logic      coin_req;
    coin_idx_t coin_sel;
    logic      coin_ack;
    logic [3:0] hopper_empty;

    modport master (
        output coin_req,
        output coin_sel,
        input  coin_ack,
        input  hopper_empty
    );

    modport slave (
        input  coin_req,
        input  coin_sel,
        output coin_ack,
        output hopper_empty
    );

endinterface

// File: rtl/change_dispenser_coin_pick.sv
// coin_pick: greedy coin selection.
//   remaining    - cents still owed
//   hopper_empty - per-coin empty flags (bit i = coin index i)
//   valid        - some stocked coin fits into remaining
//   idx          - lowest index (largest value) that fits and is stocked
module coin_pick
    import change_pkg::*;
#(
    parameter int AMT_W = 10
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [3:0]       hopper_empty,
    output logic             valid,
    output coin_idx_t        idx
);

    // Walk from the smallest coin upward so the last hit, i.e. the
    // largest qualifying coin, wins the priority.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (!hopper_empty[i] && (AMT_W'(COIN_VAL[i]) <= remaining)) begin
                valid = 1'b1;
                idx   = coin_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle request, latches change_amt (only in IDLE)
//   change_amt  - amount to pay in cents
//   hopper      - coin hopper handshake (req/sel/ack/empty flags)
//   busy        - high whenever not IDLE
//   done        - one-cycle completion pulse
//   err         - 0 OK, 1 unpayable, 2 timeout; held until next start
//   dispensed   - cents paid so far
//   remaining   - cents still owed
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W       = 10,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AMT_W-1:0]    change_amt,
    change_dispenser_if.master  hopper,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic [AMT_W-1:0]    dispensed,
    output logic [AMT_W-1:0]    remaining
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    coin_idx_t        sel_q, sel_d;
    err_t             err_q, err_d;
    logic [AMT_W-1:0] disp_q, disp_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;

    logic             pick_valid;
    coin_idx_t        pick_idx;
    logic [AMT_W-1:0] sel_val;

    coin_pick #(.AMT_W(AMT_W)) u_pick (
        .remaining    (rem_q),
        .hopper_empty (hopper.hopper_empty),
        .valid        (pick_valid),
        .idx          (pick_idx)
    );

    assign sel_val = AMT_W'(coin_value(sel_q));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        err_d   = err_q;
        disp_d  = disp_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d  = change_amt;
                    disp_d = '0;
                    err_d  = ERR_OK;
                    // Only multiples of 5 can ever be paid out exactly.
                    if ((change_amt % AMT_W'(5)) != '0) begin
                        err_d   = ERR_UNPAYABLE;
                        state_d = DONE;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end
            SELECT: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (pick_valid) begin
                    sel_d   = pick_idx;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    err_d   = ERR_UNPAYABLE;
                    state_d = DONE;
                end
            end
            REQ: begin
                // An ack in the final wait cycle still counts as a transfer.
                if (hopper.coin_ack) begin
                    req_d   = 1'b0;
                    rem_d   = rem_q - sel_val;
                    disp_d  = disp_q + sel_val;
                    state_d = SELECT;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            sel_q   <= '0;
            err_q   <= ERR_OK;
            disp_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            // Status flags are registered from the next state so they line
            // up with the state they describe.
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign hopper.coin_req = req_q;
    assign hopper.coin_sel = sel_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign dispensed       = disp_q;
    assign remaining       = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed, table-driven bench for change_dispenser (TIMEOUT_CYC = 8).
module tb_change_dispenser;
    import change_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] change_amt;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic [9:0] dispensed;
    logic [9:0] remaining;

    change_dispenser_if hop ();

    change_dispenser #(.AMT_W(10), .TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .change_amt (change_amt),
        .hopper     (hop),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dispensed  (dispensed),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  amt;
        logic [3:0]  empty;
        bit          ack_en;
        bit          restart;
        int          n_coins;
        logic [15:0] coins;     // coin k in bits [2k+1:2k]
        int          err;
        int          disp;
        int          rem;
        int          done_k;    // cycle of done, counted from start's sampling edge
        int          req_cycles;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_coin_req"},  int'(hop.coin_req), 0);
        chk({tag, "_coin_sel"},  int'(hop.coin_sel), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_err"},       int'(err), 0);
        chk({tag, "_dispensed"}, int'(dispensed), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          age;
        int          ncoin;
        int          reqcyc;
        int          done_at;
        bit          unstable;
        coin_idx_t   cur_sel;
        logic [15:0] obs;
        int          got_err;
        int          got_disp;
        int          got_rem;
        int          got_busy;
        string       tag;

        tag      = $sformatf("v%0d", id);
        age      = 0;
        ncoin    = 0;
        reqcyc   = 0;
        done_at  = 0;
        unstable = 0;
        cur_sel  = '0;
        obs      = '0;
        got_err  = -1;
        got_disp = -1;
        got_rem  = -1;
        got_busy = -1;

        hop.hopper_empty = v.empty;
        change_amt       = v.amt;
        start            = 1'b1;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (hop.coin_req) begin
                age++;
                reqcyc++;
                if (age == 1) begin
                    if (ncoin < 8) obs[2*ncoin +: 2] = hop.coin_sel;
                    ncoin++;
                    cur_sel = hop.coin_sel;
                end else if (hop.coin_sel != cur_sel) begin
                    unstable = 1;
                end
            end else begin
                age = 0;
            end
            // Hopper answers in the cycle after the request first appears.
            hop.coin_ack = v.ack_en && hop.coin_req && (age == 2);
            if (done) begin
                done_at  = k;
                got_err  = int'(err);
                got_disp = int'(dispensed);
                got_rem  = int'(remaining);
                got_busy = int'(busy);
            end
            if (v.restart && k == 3) begin
                start      = 1'b1;
                change_amt = 10'd5;
            end
        end
        hop.coin_ack = 1'b0;
        start        = 1'b0;

        chk({tag, "_done_seen"},  int'(done_at != 0), 1);
        chk({tag, "_done_cycle"}, done_at, v.done_k);
        chk({tag, "_err"},        got_err, v.err);
        chk({tag, "_dispensed"},  got_disp, v.disp);
        chk({tag, "_remaining"},  got_rem, v.rem);
        chk({tag, "_busy_at_done"}, got_busy, 1);
        chk({tag, "_n_coins"},    ncoin, v.n_coins);
        chk({tag, "_coin_seq"},   int'(obs), int'(v.coins));
        chk({tag, "_req_cycles"}, reqcyc, v.req_cycles);
        chk({tag, "_sel_stable"}, int'(unstable), 0);

        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_idle_busy"},  int'(busy), 0);
        chk({tag, "_err_held"},   int'(err), v.err);
    endtask

    initial begin
        //           amt   empty    ack rst n  coins   err disp rem done rq
        vecs[0] = '{10'd40,  4'b0000, 1, 0, 3, 16'h0039, 0, 40,  0,  11, 6};
        vecs[1] = '{10'd0,   4'b0000, 1, 0, 0, 16'h0000, 0, 0,   0,  2,  0};
        vecs[2] = '{10'd13,  4'b0000, 1, 0, 0, 16'h0000, 1, 0,   13, 1,  0};
        vecs[3] = '{10'd125, 4'b0001, 1, 0, 5, 16'h0155, 0, 125, 0,  17, 10};
        vecs[4] = '{10'd30,  4'b1100, 1, 0, 1, 16'h0001, 1, 25,  5,  5,  2};
        vecs[5] = '{10'd10,  4'b0000, 0, 0, 1, 16'h0002, 2, 0,   10, 10, 8};
        vecs[6] = '{10'd40,  4'b0000, 1, 1, 3, 16'h0039, 0, 40,  0,  11, 6};

        rst_n            = 1'b1;
        start            = 1'b0;
        change_amt       = '0;
        hop.coin_ack     = 1'b0;
        hop.hopper_empty = 4'b0000;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            @(negedge clk);
        end

        // Reset in the middle of a request: coin_req must fall before any clock edge.
        hop.hopper_empty = 4'b0000;
        change_amt       = 10'd10;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midreset_req_before", int'(hop.coin_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("post_reset");
        run_vec(7, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
